// File: rtl/unidade_desvio.sv
// Branch-resolution controller: owns the condition-flags register, holds a
// branch until pending flag writes land, evaluates it and redirects/flushes.
module unidade_desvio #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flags_we,
  input  logic [5:0]        flags_in,
  input  logic              flags_pend,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic              br_control,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic              stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [5:0]        flags_q,
  output logic              cond_err
);

  localparam int unsigned FC_EFF = (FLUSH_CYCLES == 0) ? 1 : FLUSH_CYCLES;
  localparam int unsigned CNT_W  = $clog2(FC_EFF + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_FLUSH
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       cond_q;
  logic             control_q;
  logic [7:0]       flags_ext;
  logic             accept, cond_bad, flag_sel, taken;

  // br_ready is registered, so it stays low for the first edge after reset
  assign accept    = br_valid & br_ready;
  assign cond_bad  = (cond_q > 4'd5);
  assign flags_ext = {2'b00, flags_q};
  assign flag_sel  = flags_ext[cond_q[2:0]];
  assign taken     = ~cond_bad & (control_q ? flag_sel : ~flag_sel);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE:
        if (accept) state_d = (flags_pend | flags_we) ? S_WAIT : S_EVAL;
      S_WAIT:
        if (!(flags_pend | flags_we)) state_d = S_EVAL;
      S_EVAL:
        if (taken) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(FC_EFF - 1);
        end else begin
          state_d = S_IDLE;
        end
      S_FLUSH:
        if (cnt == '0) state_d = S_IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      default:
        state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so none depend
  // combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      flags_q   <= '0;
      cond_q    <= '0;
      control_q <= 1'b0;
      pc_target <= '0;
      br_ready  <= 1'b0;
      stall     <= 1'b0;
      flush     <= 1'b0;
      pc_load   <= 1'b0;
      cond_err  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      if (flags_we) flags_q <= flags_in;
      if (accept) begin
        cond_q    <= br_cond;
        control_q <= br_control;
        pc_target <= br_target;
      end
      br_ready <= (state_d == S_IDLE);
      stall    <= (state_d != S_IDLE);
      flush    <= (state_d == S_FLUSH);
      pc_load  <= (state == S_EVAL) & taken;
      cond_err <= (state == S_EVAL) & cond_bad;
    end
  end

endmodule

// File: tb/tb_unidade_desvio.sv
// Scoreboard bench for unidade_desvio; three instances cover flush widths 2, 0 and 4.
module tb_unidade_desvio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flags_we, flags_pend, br_valid, br_control;
  logic [5:0]  flags_in;
  logic [3:0]  br_cond;
  logic [15:0] br_target;

  logic        br_ready, stall, pc_load, flush, cond_err;
  logic [15:0] pc_target;
  logic [5:0]  flags_q;
  logic        f0_ready, f0_stall, f0_pc_load, f0_flush, f0_cond_err;
  logic [15:0] f0_pc_target;
  logic [5:0]  f0_flags_q;
  logic        f4_ready, f4_stall, f4_pc_load, f4_flush, f4_cond_err;
  logic [15:0] f4_pc_target;
  logic [5:0]  f4_flags_q;

  int errs   = 0;
  int checks = 0;
  logic [5:0] mflags;

  typedef struct {
    logic        taken;
    logic [15:0] tgt;
    logic        err;
    int          w;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  unidade_desvio #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .flags_in(flags_in),
    .flags_pend(flags_pend), .br_valid(br_valid), .br_cond(br_cond),
    .br_control(br_control), .br_target(br_target), .br_ready(br_ready),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target), .flush(flush),
    .flags_q(flags_q), .cond_err(cond_err));

  unidade_desvio #(.ADDR_W(16), .FLUSH_CYCLES(0)) dut_fc0 (
    .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .flags_in(flags_in),
    .flags_pend(flags_pend), .br_valid(br_valid), .br_cond(br_cond),
    .br_control(br_control), .br_target(br_target), .br_ready(f0_ready),
    .stall(f0_stall), .pc_load(f0_pc_load), .pc_target(f0_pc_target), .flush(f0_flush),
    .flags_q(f0_flags_q), .cond_err(f0_cond_err));

  unidade_desvio #(.ADDR_W(16), .FLUSH_CYCLES(4)) dut_fc4 (
    .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .flags_in(flags_in),
    .flags_pend(flags_pend), .br_valid(br_valid), .br_cond(br_cond),
    .br_control(br_control), .br_target(br_target), .br_ready(f4_ready),
    .stall(f4_stall), .pc_load(f4_pc_load), .pc_target(f4_pc_target), .flush(f4_flush),
    .flags_q(f4_flags_q), .cond_err(f4_cond_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_flags(input logic [5:0] v);
    @(negedge clk);
    flags_we = 1'b1;
    flags_in = v;
    @(negedge clk);
    flags_we = 1'b0;
    mflags   = v;
    chk("flags_q", {26'd0, flags_q}, {26'd0, mflags});
  endtask

  // Presents a branch once every instance is ready; returns just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic ctl, input logic [15:0] t,
                       input logic exp_taken, input int w, input bit push);
    bit   ok = 1'b0;
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (br_ready && f0_ready && f4_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", {31'd0, ok}, 32'd1);
    br_valid   = 1'b1;
    br_cond    = c;
    br_control = ctl;
    br_target  = t;
    if (push) begin
      e.taken = exp_taken;
      e.tgt   = t;
      e.err   = (c > 4'd5);
      e.w     = w;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 br_valid = 1'b0;
  endtask

  // Observes one branch to completion, then pops and checks its expectation.
  // mode 1 drives the pending-flags sequence while the branch waits.
  task automatic collect(input int mode);
    exp_t        e;
    int          pcl_cnt = 0, pcl_k = 0, fl = 0, fl0 = 0, fl4 = 0;
    int          err_cnt = 0, err_k = 0, rdy_k = 0, stall_bad = 0, tk;
    logic [15:0] tgt = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (pc_load) begin
        pcl_cnt++;
        if (pcl_k == 0) begin
          pcl_k = k;
          tgt   = pc_target;
        end
      end
      if (flush)    fl++;
      if (f0_flush) fl0++;
      if (f4_flush) fl4++;
      if (cond_err) begin
        err_cnt++;
        err_k = k;
      end
      if (br_ready && rdy_k == 0) rdy_k = k;
      else if (rdy_k == 0 && !stall) stall_bad++;
      if (mode == 1) begin
        if (k == 3) begin
          flags_pend = 1'b0;
          flags_we   = 1'b1;
          flags_in   = 6'b000100;
        end else if (k == 4) begin
          flags_we = 1'b0;
          mflags   = 6'b000100;
        end
      end
      if (rdy_k != 0 && f0_ready && f4_ready) break;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e  = sb.pop_front();
    tk = e.taken ? 1 : 0;
    chk("pc_load_count", pcl_cnt, tk);
    if (e.taken) begin
      chk("pc_load_cycle", pcl_k, 2 + e.w);
      chk("pc_target", {16'd0, tgt}, {16'd0, e.tgt});
    end
    chk("flush_len_fc2", fl, 2 * tk);
    chk("flush_len_fc0", fl0, tk);
    chk("flush_len_fc4", fl4, 4 * tk);
    chk("cond_err_count", err_cnt, e.err ? 1 : 0);
    if (e.err) chk("cond_err_cycle", err_k, 2 + e.w);
    chk("ready_cycle", rdy_k, 2 + e.w + 2 * tk);
    chk("stall_while_busy", stall_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] t;
    int          pcl;
    rst_n = 1'b0; flags_we = 1'b0; flags_in = '0; flags_pend = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_control = 1'b0; br_target = '0;
    mflags = '0;
    repeat (3) @(negedge clk);
    chk("rst_br_ready", {31'd0, br_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_flags_q", {26'd0, flags_q}, 32'd0);
    chk("rst_pc_target", {16'd0, pc_target}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, br_ready}, 32'd1);

    // basic taken branch
    set_flags(6'b010101);
    issue(4'd0, 1'b1, 16'h0040, 1'b1, 0, 1'b1);
    collect(0);

    // condition sweep
    set_flags(6'b111000);
    for (int c = 0; c < 6; c++) begin
      for (int ctl = 0; ctl < 2; ctl++) begin
        t = 16'h1000 + 16'(c * 2 + ctl);
        issue(4'(c), 1'(ctl), t, (mflags[c] == 1'(ctl)), 0, 1'b1);
        collect(0);
      end
    end

    // pending flags: decision must use the flag written after the wait
    set_flags(6'b000000);
    flags_pend = 1'b1;
    issue(4'd2, 1'b1, 16'h2222, 1'b1, 4, 1'b1);
    collect(1);
    chk("flags_after_wait", {26'd0, flags_q}, {26'd0, mflags});

    // invalid condition
    issue(4'd9, 1'b1, 16'hBEEF, 1'b0, 0, 1'b1);
    collect(0);

    // reset in the second flush cycle
    set_flags(6'b010101);
    issue(4'd0, 1'b1, 16'h0123, 1'b1, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pc_load_before", {31'd0, pc_load}, 32'd1);
    @(negedge clk);
    chk("midrst_flush_before", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flush", {31'd0, flush}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("midrst_flags_q", {26'd0, flags_q}, 32'd0);
    mflags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pcl = 0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, br_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (pc_load) pcl++;
      @(negedge clk);
    end
    chk("midrst_no_stale_pc_load", pcl, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
